// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word reads over req/ack and
// buffers each returned instruction for the IF/ID register until it is captured.
module if_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        ifid_load,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        fetch_valid
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] next_pc_q, next_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;

    logic [31:0] target;
    logic [31:0] resume_pc;
    logic        ack;
    logic        unused_pc_lsb;

    assign target        = {redirect_pc[31:2], 2'b00};
    assign unused_pc_lsb = ^redirect_pc[1:0];
    // An ack is only meaningful while our request is actually on the bus.
    assign ack           = imem_ack & req_q;
    // In DISCARD the newest redirect seen this cycle overrides the stored target.
    assign resume_pc     = redirect ? target : next_pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            req_q     <= 1'b0;
            addr_q    <= RESET_VECTOR;
            next_pc_q <= RESET_VECTOR + 32'd4;
            instr_q   <= NOP_INSTR;
            pc_q      <= 32'h0000_0000;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            next_pc_q <= next_pc_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        addr_d    = addr_q;
        next_pc_d = next_pc_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        valid_d   = valid_q;

        case (state_q)
            FETCH: begin
                if (!req_q) begin
                    // Idle only straight out of reset: nothing outstanding, so a
                    // redirect can retarget the address before it goes out.
                    req_d = 1'b1;
                    if (redirect) begin
                        addr_d    = target;
                        next_pc_d = target + 32'd4;
                    end
                end else if (redirect) begin
                    if (ack) begin
                        addr_d    = target;
                        next_pc_d = target + 32'd4;
                    end else begin
                        next_pc_d = target;
                        state_d   = DISCARD;
                    end
                end else if (ack) begin
                    instr_d   = imem_rdata;
                    pc_d      = addr_q;
                    valid_d   = 1'b1;
                    req_d     = 1'b0;
                    addr_d    = next_pc_q;
                    next_pc_d = next_pc_q + 32'd4;
                    state_d   = HOLD;
                end
            end

            HOLD: begin
                if (redirect || ifid_load) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    req_d   = 1'b1;
                    state_d = FETCH;
                    if (redirect) begin
                        addr_d    = target;
                        next_pc_d = target + 32'd4;
                    end
                end
            end

            DISCARD: begin
                // The bus address must not move until the stale read completes.
                if (ack) begin
                    addr_d    = resume_pc;
                    next_pc_d = resume_pc + 32'd4;
                    state_d   = FETCH;
                end else if (redirect) begin
                    next_pc_d = target;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_out   = instr_q;
    assign pc_out      = pc_q;
    assign fetch_valid = valid_q;

endmodule
